// File: rtl/ram_blit_master_pkg.sv
// Shared bus widths, FSM state encodings and state-class helpers for the RAM blit master.
package ram_blit_master_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 5;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_WR      = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;

  // Request through last write: the window in which we hold (or wait for) the bus.
  function automatic logic in_transfer(state_t s);
    return (s == S_REQ) || (s == S_RD) || (s == S_RD_WAIT) || (s == S_WR);
  endfunction

  function automatic logic reading(state_t s);
    return (s == S_RD) || (s == S_RD_WAIT);
  endfunction

endpackage

// File: rtl/ram_blit_master.sv
// Bus initiator copying len bytes src->dst over the shared 8-bit RAM bus, XOR-ing each byte.
// Three bus cycles per byte (RD, RD_WAIT, WR); the bus is held for the whole copy.
module ram_blit_master
  import ram_blit_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] xor_mask,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              oe,
  inout  wire  [DATA_W-1:0] data
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len;
          mask_d  = xor_mask;
          state_d = (len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_RD;
      end
      S_RD: begin
        state_d = bus_gnt ? S_RD_WAIT : S_ABORT;
      end
      S_RD_WAIT: begin
        if (!bus_gnt) begin
          state_d = S_ABORT;
        end else begin
          wbuf_d  = data ^ mask_q;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!bus_gnt) begin
          state_d = S_ABORT;
        end else begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they arrive registered,
  // aligned with the state they belong to.
  always_comb begin
    busy_d = in_transfer(state_d);
    req_d  = in_transfer(state_d);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ABORT);
    oe_d   = reading(state_d);
    we_d   = (state_d == S_WR);
    addr_d = '0;
    if (reading(state_d))       addr_d = src_d;
    else if (state_d == S_WR)   addr_d = dst_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mask_q  <= '0;
      wbuf_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mask_q  <= mask_d;
      wbuf_q  <= wbuf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bus_req = req_q;
  assign addr    = addr_q;
  assign we      = we_q;
  assign oe      = oe_q;

  // Driver enable is exactly we; the RAM only drives when oe & ~we, so no contention.
  assign data = we_q ? wbuf_q : {DATA_W{1'bz}};

endmodule
